// File: rtl/game_ctrl_pkg.sv
// Shared game-state and winner codes, used by this controller and the ball block.
// Also holds the controller's internal state type and its mapping to the state code.
package game_ctrl_pkg;

   localparam logic [1:0] GS_IDLE = 2'b00;
   localparam logic [1:0] GS_PLAY = 2'b01;
   localparam logic [1:0] GS_HOLD = 2'b10;
   localparam logic [1:0] GS_OVER = 2'b11;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PLAY  = 3'd1,
      ST_SERVE = 3'd2,
      ST_PAUSE = 3'd3,
      ST_OVER  = 3'd4
   } state_t;

   // SERVE and PAUSE both present as HOLD to the ball block.
   function automatic logic [1:0] gs_code(input state_t s);
      case (s)
         ST_PLAY:  gs_code = GS_PLAY;
         ST_SERVE: gs_code = GS_HOLD;
         ST_PAUSE: gs_code = GS_HOLD;
         ST_OVER:  gs_code = GS_OVER;
         default:  gs_code = GS_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/game_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, equal-sample counter, one-cycle pulse
// on an accepted rising level. Raw press to pulse takes 2 + DEB_TICKS cycles.
module game_ctrl_btn_debounce #(
   parameter int DEB_TICKS = 4
) (
   input  logic clk1,
   input  logic reset,
   input  logic btn,
   output logic ev
);

   localparam int CW = $clog2(DEB_TICKS + 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_level;
   logic [CW-1:0] r_cnt;
   logic          r_ev;

   // The counter only runs while the synchronized sample differs from the
   // accepted level; the DEB_TICKS-th differing sample flips the level.
   always_ff @(posedge clk1) begin
      if (!reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_level <= 1'b0;
         r_cnt   <= '0;
         r_ev    <= 1'b0;
      end else begin
         r_sync1 <= btn;
         r_sync2 <= r_sync1;
         r_ev    <= 1'b0;
         if (r_sync2 == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CW'(DEB_TICKS - 1)) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
            r_ev    <= r_sync2;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign ev = r_ev;

endmodule

// File: rtl/game_ctrl.sv
// Game-flow controller: debounced start/pause, point detection, serve hold-off
// and match-over detection driving the 2-bit game-state code for the ball block.
//
// state    | meaning
// ST_IDLE  | waiting for start, code 00
// ST_PLAY  | ball in motion, code 01
// ST_SERVE | hold-off after start or a point, code 10, serve_left counting
// ST_PAUSE | paused by player, code 10
// ST_OVER  | match won, code 11, left only by reset
module game_ctrl
   import game_ctrl_pkg::*;
#(
   parameter int DEB_TICKS   = 4,
   parameter int SERVE_TICKS = 120,
   parameter int WIN_SCORE   = 7
) (
   input  logic       clk1,
   input  logic       reset,
   input  logic       btn_start,
   input  logic       btn_pause,
   input  logic [3:0] p1s,
   input  logic [3:0] p2s,
   output logic [1:0] score,
   output logic [1:0] winner,
   output logic       point_p1,
   output logic       point_p2,
   output logic [6:0] serve_left
);

   state_t     r_state;
   state_t     w_state_nxt;
   logic [1:0] r_score;
   logic [1:0] r_winner;
   logic [1:0] w_winner_nxt;
   logic [6:0] r_serve_left;
   logic [6:0] w_serve_nxt;
   logic [3:0] r_p1s_q;
   logic [3:0] r_p2s_q;
   logic       r_point_p1;
   logic       r_point_p2;
   logic       w_start_ev;
   logic       w_pause_ev;
   logic       w_pt1;
   logic       w_pt2;
   logic       w_p1_won;
   logic       w_p2_won;

   game_ctrl_btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_start (
      .clk1  (clk1),
      .reset (reset),
      .btn   (btn_start),
      .ev    (w_start_ev)
   );

   game_ctrl_btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_pause (
      .clk1  (clk1),
      .reset (reset),
      .btn   (btn_pause),
      .ev    (w_pause_ev)
   );

   assign w_pt1    = (p1s != r_p1s_q);
   assign w_pt2    = (p2s != r_p2s_q);
   // Scores past WIN_SCORE still count as a win in case the ball block overshoots.
   assign w_p1_won = (p1s >= 4'(WIN_SCORE));
   assign w_p2_won = (p2s >= 4'(WIN_SCORE));

   always_comb begin
      w_state_nxt  = r_state;
      w_serve_nxt  = r_serve_left;
      w_winner_nxt = r_winner;
      case (r_state)
         ST_IDLE: begin
            if (w_start_ev) begin
               w_state_nxt = ST_SERVE;
               w_serve_nxt = 7'(SERVE_TICKS);
            end
         end
         ST_PLAY: begin
            if (w_pt1 || w_pt2) begin
               if (w_p1_won) begin
                  w_state_nxt  = ST_OVER;
                  w_winner_nxt = WIN_P1;
               end else if (w_p2_won) begin
                  w_state_nxt  = ST_OVER;
                  w_winner_nxt = WIN_P2;
               end else begin
                  w_state_nxt = ST_SERVE;
                  w_serve_nxt = 7'(SERVE_TICKS);
               end
            end else if (w_pause_ev) begin
               w_state_nxt = ST_PAUSE;
            end
         end
         ST_SERVE: begin
            if (r_serve_left <= 7'd1) begin
               w_state_nxt = ST_PLAY;
               w_serve_nxt = 7'd0;
            end else begin
               w_serve_nxt = r_serve_left - 7'd1;
            end
         end
         ST_PAUSE: begin
            if (w_pause_ev || w_start_ev) begin
               w_state_nxt = ST_PLAY;
            end
         end
         ST_OVER: begin
         end
         default: begin
            w_state_nxt  = ST_IDLE;
            w_serve_nxt  = 7'd0;
            w_winner_nxt = WIN_NONE;
         end
      endcase
   end

   always_ff @(posedge clk1) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_score      <= GS_IDLE;
         r_winner     <= WIN_NONE;
         r_serve_left <= 7'd0;
         r_p1s_q      <= 4'd0;
         r_p2s_q      <= 4'd0;
         r_point_p1   <= 1'b0;
         r_point_p2   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_score      <= gs_code(w_state_nxt);
         r_winner     <= w_winner_nxt;
         r_serve_left <= w_serve_nxt;
         r_p1s_q      <= p1s;
         r_p2s_q      <= p2s;
         r_point_p1   <= w_pt1;
         r_point_p2   <= w_pt2;
      end
   end

   assign score      = r_score;
   assign winner     = r_winner;
   assign point_p1   = r_point_p1;
   assign point_p2   = r_point_p2;
   assign serve_left = r_serve_left;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with default parameters (DEB 4, SERVE 120, WIN 7).
// Inputs are driven and outputs sampled 1 time unit after each rising clk1 edge.
module tb_game_ctrl;

   logic       clk1 = 1'b0;
   logic       reset;
   logic       btn_start;
   logic       btn_pause;
   logic [3:0] p1s;
   logic [3:0] p2s;
   logic [1:0] score;
   logic [1:0] winner;
   logic       point_p1;
   logic       point_p2;
   logic [6:0] serve_left;

   int n_checks = 0;
   int n_err    = 0;

   game_ctrl dut (
      .clk1       (clk1),
      .reset      (reset),
      .btn_start  (btn_start),
      .btn_pause  (btn_pause),
      .p1s        (p1s),
      .p2s        (p2s),
      .score      (score),
      .winner     (winner),
      .point_p1   (point_p1),
      .point_p2   (point_p2),
      .serve_left (serve_left)
   );

   always #5 clk1 = ~clk1;

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk1);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset     = 1'b0;
      btn_start = 1'b0;
      btn_pause = 1'b0;
      p1s       = 4'd0;
      p2s       = 4'd0;

      // Reset
      ticks(2);
      chk("rst_score", 8'(score), 8'h0);
      chk("rst_winner", 8'(winner), 8'h0);
      chk("rst_serve", 8'(serve_left), 8'd0);
      chk("rst_pt1", 8'(point_p1), 8'h0);
      reset = 1'b1;
      ticks(2);

      // Points in IDLE pulse but do not move the FSM
      p1s = 4'd3;
      p2s = 4'd5;
      ticks(1);
      chk("idle_pt1", 8'(point_p1), 8'h1);
      chk("idle_pt2", 8'(point_p2), 8'h1);
      chk("idle_pt_score", 8'(score), 8'h0);
      ticks(1);
      chk("idle_pt1_off", 8'(point_p1), 8'h0);

      // Start pulse of 3 cycles is rejected
      btn_start = 1'b1;
      ticks(3);
      btn_start = 1'b0;
      ticks(10);
      chk("short_start", 8'(score), 8'h0);

      // Start held 10 cycles: HOLD at cycle 7, PLAY 120 cycles later
      btn_start = 1'b1;
      ticks(6);
      chk("start_c6", 8'(score), 8'h0);
      ticks(1);
      chk("start_c7", 8'(score), 8'h2);
      chk("start_serve120", 8'(serve_left), 8'd120);
      ticks(3);
      btn_start = 1'b0;
      chk("serve_c10", 8'(serve_left), 8'd117);
      ticks(116);
      chk("serve_last", 8'(serve_left), 8'd1);
      chk("serve_last_score", 8'(score), 8'h2);
      ticks(1);
      chk("play_score", 8'(score), 8'h1);
      chk("play_serve0", 8'(serve_left), 8'd0);

      // Player-1 point 3->4
      p1s = 4'd4;
      ticks(1);
      chk("p1pt_pulse", 8'(point_p1), 8'h1);
      chk("p1pt_p2", 8'(point_p2), 8'h0);
      chk("p1pt_score", 8'(score), 8'h2);
      chk("p1pt_serve", 8'(serve_left), 8'd120);
      ticks(1);
      chk("p1pt_pulse_off", 8'(point_p1), 8'h0);
      chk("p1pt_serve119", 8'(serve_left), 8'd119);
      ticks(118);
      chk("p1pt_hold", 8'(score), 8'h2);
      ticks(1);
      chk("p1pt_resume", 8'(score), 8'h1);

      // Pause, then resume with a second press
      btn_pause = 1'b1;
      ticks(6);
      chk("pause_c6", 8'(score), 8'h1);
      ticks(1);
      chk("pause_c7", 8'(score), 8'h2);
      chk("pause_serve0", 8'(serve_left), 8'd0);
      btn_pause = 1'b0;
      ticks(8);
      chk("pause_held", 8'(score), 8'h2);
      btn_pause = 1'b1;
      ticks(7);
      chk("unpause", 8'(score), 8'h1);
      btn_pause = 1'b0;
      ticks(8);
      chk("unpause_stay", 8'(score), 8'h1);

      // Pause event and player-2 point in the same cycle: point wins
      btn_pause = 1'b1;
      ticks(6);
      p2s = 4'd6;
      ticks(1);
      chk("race_pt2", 8'(point_p2), 8'h1);
      chk("race_score", 8'(score), 8'h2);
      chk("race_serve", 8'(serve_left), 8'd120);
      btn_pause = 1'b0;
      ticks(120);
      chk("race_resume", 8'(score), 8'h1);

      // Player 2 reaches WIN_SCORE
      p2s = 4'd7;
      ticks(1);
      chk("win2_score", 8'(score), 8'h3);
      chk("win2_winner", 8'(winner), 8'h2);
      chk("win2_pt2", 8'(point_p2), 8'h1);
      btn_start = 1'b1;
      btn_pause = 1'b1;
      ticks(10);
      chk("over_btn_score", 8'(score), 8'h3);
      chk("over_btn_winner", 8'(winner), 8'h2);
      btn_start = 1'b0;
      btn_pause = 1'b0;
      ticks(2);
      reset = 1'b0;
      ticks(1);
      chk("rst_over_score", 8'(score), 8'h0);
      chk("rst_over_winner", 8'(winner), 8'h0);
      chk("rst_over_pt2", 8'(point_p2), 8'h0);
      reset = 1'b1;

      // Both players reach WIN_SCORE in the same cycle
      p1s = 4'd6;
      p2s = 4'd6;
      ticks(4);
      chk("idle2_score", 8'(score), 8'h0);
      btn_start = 1'b1;
      ticks(7);
      chk("start2", 8'(score), 8'h2);
      btn_start = 1'b0;
      ticks(120);
      chk("play2", 8'(score), 8'h1);
      p1s = 4'd7;
      p2s = 4'd7;
      ticks(1);
      chk("tie_score", 8'(score), 8'h3);
      chk("tie_winner", 8'(winner), 8'h1);
      chk("tie_pt1", 8'(point_p1), 8'h1);
      chk("tie_pt2", 8'(point_p2), 8'h1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
